// File: rtl/bf_operand_sel.sv
// N:1 registered operand selector for the NTT butterfly. A beat appears 1 cycle after accept.
// A 2-entry main+skid buffer gives full throughput. in_ready depends on registered state only.
module bf_operand_sel #(
    parameter int WIDTH       = 16,
    parameter int NUM_IN      = 4,
    parameter int SEL_W       = 2,
    parameter int DEFAULT_SEL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_sticky,
    input  logic                    clr_err
);

    logic [WIDTH-1:0] sel_word;
    logic             sel_bad;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic             skid_valid;
    logic             accept;
    logic             fire;

    // The loop never indexes past NUM_IN, so codes >= NUM_IN fall back to DEFAULT_SEL.
    always_comb begin
        sel_word = in_data[DEFAULT_SEL*WIDTH +: WIDTH];
        sel_bad  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_word = in_data[i*WIDTH +: WIDTH];
                sel_bad  = 1'b0;
            end
        end
    end

    assign in_ready = !skid_valid && !rst;
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data    <= '0;
            out_sel_err <= 1'b0;
            out_valid   <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (skid_valid && fire) begin
            // in_ready is low here, so no new beat competes with the skid drain.
            out_data    <= skid_data;
            out_sel_err <= skid_err;
            skid_valid  <= 1'b0;
        end else if (accept && (!out_valid || fire)) begin
            out_data    <= sel_word;
            out_sel_err <= sel_bad;
            out_valid   <= 1'b1;
        end else if (accept) begin
            skid_data   <= sel_word;
            skid_err    <= sel_bad;
            skid_valid  <= 1'b1;
        end else if (fire) begin
            out_valid   <= 1'b0;
        end
    end

    // A set in the same cycle as clr_err wins, so no bad beat goes unreported.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (accept && sel_bad) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: doc/bf_operand_sel.md
Name: bf_operand_sel

Overview:
- Parametrised, registered N:1 operand selector with a valid/ready handshake, feeding operands to the NTT butterfly datapath.
- Each accepted input beat selects one of NUM_IN WIDTH-bit words using that beat's select code.
- Results are buffered in a 2-entry skid buffer. This gives full throughput and no combinational ready path from output to input.
- Out-of-range select codes map to a configurable default input. Each such beat is flagged, and a sticky error flag is also set.

Parameters:
- WIDTH, 16, data width of each input word and of the output.
- NUM_IN, 4, number of selectable inputs; 2 <= NUM_IN <= 2**SEL_W.
- SEL_W, 2, select code width.
- DEFAULT_SEL, 2, input index used when the select code is >= NUM_IN; must be < NUM_IN.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  packed inputs; word i = in_data[i*WIDTH +: WIDTH].
- in_sel  in  SEL_W  select code for the current beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- out_data  out  WIDTH  selected word.
- out_sel_err  out  1  this output beat used an out-of-range select.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- err_sticky  out  1  sticky flag: some accepted beat had an out-of-range select.
- clr_err  in  1  clears err_sticky.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Handshake events: accept = in_valid && in_ready. Fire = out_valid && out_ready.
- Select function:
  - sel_word = word[in_sel] if in_sel < NUM_IN, otherwise word[DEFAULT_SEL].
  - sel_bad = (in_sel >= NUM_IN).
  - Selection is combinational and is captured only on accept.
- Storage:
  - Main register: out_data, out_sel_err, out_valid.
  - Skid register: skid_data, skid_err, skid_valid.
- in_ready = !skid_valid && !rst. It is a function of registered state only, never of out_ready.
- Register updates per cycle, in priority order:
  - skid_valid && fire: main <= skid; skid_valid <= 0. No accept is possible in this case because in_ready = 0.
  - accept && (!out_valid || fire): main <= {sel_word, sel_bad}; out_valid <= 1.
  - accept && out_valid && !fire: skid <= {sel_word, sel_bad}; skid_valid <= 1.
  - fire && !accept && !skid_valid: out_valid <= 0. out_data holds its last value.
  - Otherwise: hold.
- Latency: 1 cycle from accept to out_valid when the main register is free.
- Throughput: 1 beat/cycle with out_ready held high.
- Ordering: beats leave in acceptance order, with no loss and no duplication.
- Stability: while out_valid && !out_ready, out_data and out_sel_err must not change.
- err_sticky:
  - Set on accept with sel_bad.
  - Cleared by clr_err when no set occurs in the same cycle.
  - Simultaneous set and clr_err: set wins.
- Reset (any cycle, including mid-transfer with the skid full):
  - out_valid = 0, out_data = 0, out_sel_err = 0, err_sticky = 0, skid_valid = 0, skid contents = 0.
  - in_ready = 0 while rst is high and 1 on the first cycle after reset.
  - Beats presented during reset are discarded.
- in_sel is don't-care when in_valid is 0.

Test Plan:
1. Reset: assert rst for 2 cycles with in_valid = 1 -> out_valid = 0, out_data = 0x0000, err_sticky = 0, in_ready = 0 during reset and 1 after; no beat emitted.
2. Streaming: words = {0x0004, 0x0003, 0x0002, 0x0001} (word3..word0), out_ready = 1, in_sel = 0,1,2,3 on consecutive cycles -> out_data = 0x0001, 0x0002, 0x0003, 0x0004, each one cycle after its accept; in_ready stays 1.
3. Backpressure: out_ready = 0, two beats with sel = 1 then sel = 2 -> in_ready = 0 after the second accept; out_data stays 0x0002. Raise out_ready -> 0x0002 then 0x0003; in_ready returns to 1 one cycle after the first fire.
4. Out-of-range (NUM_IN = 3, SEL_W = 2, DEFAULT_SEL = 2): in_sel = 3 -> out_data = word2 = 0x0003, out_sel_err = 1, err_sticky = 1. Pulse clr_err -> err_sticky = 0. A second bad beat accepted in the same cycle as clr_err -> err_sticky stays 1.
5. Reset mid-operation: skid full with out_ready = 0, assert rst for 1 cycle -> next cycle out_valid = 0, in_ready = 1; both buffered beats are never emitted.
6. Random valid/ready stress (10k beats, random sel including out-of-range codes) -> scoreboard confirms order and data, that out_sel_err matches the expected per-beat flag, and that output is stable under stall.
